mem_port_sched: RTL and testbench
=================================

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 Parameter: AW, 16, address width of the shared memory.
REQ-002 Parameter: DW, 32, data width of the shared memory.
REQ-003 Parameter: NREQ, 4, number of read requesters (fixed at 4).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: rq_valid  in  4  per-requester read request.
REQ-007 Port: rq_addr  in  64  4x16 read addresses; lane i = bits [16i+15:16i].
REQ-008 Port: rq_ready  out  4  combinational grant; handshake when rq_valid[i] & rq_ready[i].
REQ-009 Port: rsp_valid  out  4  registered per-lane response strobe.
REQ-010 Port: rsp_data  out  128  4x32 registered response data, same lane layout.
REQ-011 Port: wr_valid / wr_addr / wr_data  in  1/16/32  single write requester.
REQ-012 Port: wr_ready  out  1  write accepted when wr_valid & wr_ready.
REQ-013 Port: clr_start  in  1; clr_value  in  32; clr_busy  out  1; clr_done  out  1 -- clear engine.
REQ-014 Port: mem_read0 / mem_read1  out  16 each; mem_out0 / mem_out1  in  32 each -- memory read ports, registered inside memory, 1-cycle latency.
REQ-015 Port: mem_writing  out  1; mem_waddr  out  16; mem_wdata  out  32 -- memory write port.

Function
REQ-016 The block SHALL grant up to two valid requesters per cycle, scanning round-robin from rr_ptr upward mod 4: first hit to port 0, second hit to port 1.
REQ-017 Each requester SHALL receive at most one grant per cycle; rq_ready[i]=1 only for granted lanes.
REQ-018 mem_read0/1 SHALL be driven combinationally with the granted lane's address, or 0 when the port has no grant.
REQ-019 After a cycle with at least one grant, rr_ptr SHALL become (highest-priority-order last granted index + 1) mod 4; otherwise it holds.
REQ-020 A read accepted in cycle N SHALL produce rsp_valid[i]=1 for exactly cycle N+2, with rsp_data lane i = mem_outX captured at the end of cycle N+1.
REQ-021 rsp_data lanes SHALL hold their last value when rsp_valid is low.
REQ-022 Back-to-back grants to the same lane SHALL yield back-to-back responses in order.
REQ-023 Outside clear, wr_ready SHALL be 1 and mem_writing = wr_valid, with mem_waddr/mem_wdata passed through.
REQ-024 A same-cycle read and write to one address SHALL return the pre-write data.
REQ-025 Clear FSM states: IDLE, CLEAR, DONE.
REQ-026 IDLE->CLEAR on clr_start: latch clr_value, counter=0; a write presented in the same cycle is still accepted.
REQ-027 In CLEAR: wr_ready=0, clr_busy=1, mem_writing=1, mem_waddr=counter, mem_wdata=latched value; the counter increments each cycle.
REQ-028 In CLEAR with counter=0xFFFF: the final write is issued, then the FSM moves to DONE; the counter SHALL NOT wrap.
REQ-029 DONE SHALL last one cycle with clr_done=1 and clr_busy=0, then return to IDLE.
REQ-030 clr_start SHALL be ignored in CLEAR and DONE; reads SHALL continue unaffected during clear.

Reset
REQ-031 While rst_n=0, the block SHALL force rq_ready, rsp_valid, rsp_data, mem_read0/1, mem_writing, mem_waddr, mem_wdata, wr_ready, clr_busy and clr_done to 0, and set rr_ptr=0 and FSM=IDLE.
REQ-032 Reset mid-clear or with reads in flight SHALL abort the clear and discard pending responses; no rsp_valid follows reset release.

Configuration
REQ-033 Macro MEM_PORT_SCHED_CLEAR_EN defined: the clear engine (REQ-025..030) is built.
REQ-034 Macro absent: clr_start and clr_value are ignored, clr_busy=clr_done=0, wr_ready=1 out of reset, and the FSM and counter are not built.

Verification
REQ-035 rq_valid=4'b1111, rr_ptr=0 -> grants lanes 0,1; next cycle lanes 2,3; rsp_valid 4'b0011 two cycles after the first grant.
REQ-036 Lane 2 requests addr 0x0010 while mem holds 0xDEADBEEF -> rsp_valid[2] at N+2 with lane 2 data 0xDEADBEEF.
REQ-037 Write 0x12345678 to 0x0005 and read 0x0005 in the same cycle -> old value; a repeat read -> 0x12345678.
REQ-038 clr_start with clr_value=0xA5A5A5A5 -> 65536 consecutive writes, 0x0000..0xFFFF, wr_ready=0 throughout, then one clr_done pulse; reads of 0x8000 afterwards -> 0xA5A5A5A5.
REQ-039 rst_n low at clear counter 0x0100 -> all outputs 0 immediately; after release, clr_busy=0 and wr_ready=1.
REQ-040 Build without MEM_PORT_SCHED_CLEAR_EN, pulse clr_start -> no mem_writing, clr_done stays 0.

Source files
------------

// File: rtl/mem_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sched
// Purpose  : Two-port round-robin read scheduler for four requesters, write
//            pass-through and an optional memory clear engine, built only
//            when MEM_PORT_SCHED_CLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_sched #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      rq_valid,
  input  logic [NREQ*AW-1:0]   rq_addr,
  output logic [NREQ-1:0]      rq_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*DW-1:0]   rsp_data,
  input  logic                 wr_valid,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  output logic                 wr_ready,
  input  logic                 clr_start,
  input  logic [DW-1:0]        clr_value,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [AW-1:0]        mem_read0,
  output logic [AW-1:0]        mem_read1,
  input  logic [DW-1:0]        mem_out0,
  input  logic [DW-1:0]        mem_out1,
  output logic                 mem_writing,
  output logic [AW-1:0]        mem_waddr,
  output logic [DW-1:0]        mem_wdata
);

  localparam int c_LW = $clog2(NREQ);

  logic [c_LW-1:0]   r_rr_ptr;
  logic [c_LW-1:0]   w_rot_idx [NREQ];
  logic              w_g0_hit;
  logic              w_g1_hit;
  logic [c_LW-1:0]   w_g0_idx;
  logic [c_LW-1:0]   w_g1_idx;
  logic              w_g0;
  logic              w_g1;

  logic              r_s1_v0;
  logic              r_s1_v1;
  logic [c_LW-1:0]   r_s1_l0;
  logic [c_LW-1:0]   r_s1_l1;
  logic [NREQ-1:0]   w_rsp_valid_nxt;
  logic [NREQ*DW-1:0] w_rsp_data_nxt;

  logic              w_clearing;
  logic              w_clr_done;
  logic [AW-1:0]     w_clr_addr;
  logic [DW-1:0]     w_clr_data;

  // Scan order starts at the round-robin pointer and wraps modulo NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign w_rot_idx[gi] = r_rr_ptr + c_LW'(gi);
  end

  always_comb begin
    w_g0_hit = 1'b0;
    w_g1_hit = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (rq_valid[w_rot_idx[k]]) begin
        if (!w_g0_hit) begin
          w_g0_hit = 1'b1;
          w_g0_idx = w_rot_idx[k];
        end else if (!w_g1_hit) begin
          w_g1_hit = 1'b1;
          w_g1_idx = w_rot_idx[k];
        end
      end
    end
  end

  assign w_g0 = w_g0_hit & rst_n;
  assign w_g1 = w_g1_hit & rst_n;

  always_comb begin
    rq_ready = '0;
    if (w_g0) rq_ready[w_g0_idx] = 1'b1;
    if (w_g1) rq_ready[w_g1_idx] = 1'b1;
  end

  assign mem_read0 = w_g0 ? rq_addr[int'(w_g0_idx)*AW +: AW] : '0;
  assign mem_read1 = w_g1 ? rq_addr[int'(w_g1_idx)*AW +: AW] : '0;

  // The pointer moves past the last lane served, so port 1's lane wins when both fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_g1) begin
      r_rr_ptr <= w_g1_idx + c_LW'(1);
    end else if (w_g0) begin
      r_rr_ptr <= w_g0_idx + c_LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v0 <= 1'b0;
      r_s1_v1 <= 1'b0;
      r_s1_l0 <= '0;
      r_s1_l1 <= '0;
    end else begin
      r_s1_v0 <= w_g0;
      r_s1_v1 <= w_g1;
      r_s1_l0 <= w_g0_idx;
      r_s1_l1 <= w_g1_idx;
    end
  end

  // Memory data is valid the cycle after the grant; lanes not returning hold.
  always_comb begin
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = rsp_data;
    if (r_s1_v0) begin
      w_rsp_valid_nxt[r_s1_l0]               = 1'b1;
      w_rsp_data_nxt[int'(r_s1_l0)*DW +: DW] = mem_out0;
    end
    if (r_s1_v1) begin
      w_rsp_valid_nxt[r_s1_l1]               = 1'b1;
      w_rsp_data_nxt[int'(r_s1_l1)*DW +: DW] = mem_out1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= w_rsp_valid_nxt;
      rsp_data  <= w_rsp_data_nxt;
    end
  end

`ifdef MEM_PORT_SCHED_CLEAR_EN
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CLEAR = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [DW-1:0] r_clr_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_clr_cnt <= '0;
      r_clr_val <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (clr_start) begin
            r_state   <= c_ST_CLEAR;
            r_clr_cnt <= '0;
            r_clr_val <= clr_value;
          end
        end
        c_ST_CLEAR: begin
          // Counter parks at the last address instead of wrapping.
          if (r_clr_cnt == '1) begin
            r_state <= c_ST_DONE;
          end else begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign w_clearing = (r_state == c_ST_CLEAR);
  assign w_clr_done = (r_state == c_ST_DONE);
  assign w_clr_addr = r_clr_cnt;
  assign w_clr_data = r_clr_val;
`else
  logic w_unused_clr;

  assign w_unused_clr = ^{clr_start, clr_value};
  assign w_clearing   = 1'b0;
  assign w_clr_done   = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
`endif

  assign clr_busy    = w_clearing;
  assign clr_done    = w_clr_done;
  assign wr_ready    = rst_n & ~w_clearing;
  assign mem_writing = rst_n & (w_clearing | wr_valid);

  always_comb begin
    mem_waddr = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (w_clearing) begin
        mem_waddr = w_clr_addr;
        mem_wdata = w_clr_data;
      end else begin
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_sched
// Purpose  : Randomized self-checking bench for mem_port_sched with a
//            behavioural memory and scheduler model; clear-engine scenarios
//            follow MEM_PORT_SCHED_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   rq_valid;
  logic [63:0]  rq_addr;
  logic [3:0]   rq_ready;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic         wr_valid;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wr_ready;
  logic         clr_start;
  logic [31:0]  clr_value;
  logic         clr_busy;
  logic         clr_done;
  logic [15:0]  mem_read0;
  logic [15:0]  mem_read1;
  logic [31:0]  mem_out0;
  logic [31:0]  mem_out1;
  logic         mem_writing;
  logic [15:0]  mem_waddr;
  logic [31:0]  mem_wdata;

  always #5 clk = ~clk;

  mem_port_sched dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_addr(rq_addr), .rq_ready(rq_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_read0(mem_read0), .mem_read1(mem_read1), .mem_out0(mem_out0), .mem_out1(mem_out1),
    .mem_writing(mem_writing), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Environment memory: registered read, read-before-write on the same address.
  logic [31:0] tb_mem [65536];
  always @(posedge clk) begin
    mem_out0 <= tb_mem[mem_read0];
    mem_out1 <= tb_mem[mem_read1];
    if (mem_writing) tb_mem[mem_waddr] = mem_wdata;
  end

`ifdef MEM_PORT_SCHED_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  // Reference model state
  logic [31:0] model_mem [65536];
  logic [3:0]  exp_v [4];
  logic [31:0] exp_d [4][4];
  logic [31:0] exp_lane [4];
  int          cyc;
  int          m_ptr;
  int          m_cs;
  logic [31:0] m_cv;
  int          n_vec;
  int          n_bad;

  task automatic model_reset();
    m_ptr = 0;
    m_cs  = -1;
    m_cv  = '0;
    for (int s = 0; s < 4; s++) begin
      exp_v[s] = '0;
      exp_lane[s] = '0;
    end
  endtask

  function automatic logic [63:0] rand_addrs();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: check registered outputs, apply inputs, check combinational outputs.
  task automatic run_cycle(input logic [3:0] v, input logic [63:0] a, input logic wv,
                           input logic [15:0] wa, input logic [31:0] wd,
                           input logic cs, input logic [31:0] cv);
    int slot, nslot, off, last;
    int order[$];
    logic [3:0]   e_rdy;
    logic [15:0]  e_r0, e_r1, e_wa;
    logic [31:0]  e_wd;
    logic [127:0] e_data;
    logic         e_wr, e_wrdy, e_busy, e_done, in_clr;
    @(negedge clk);
    slot = cyc % 4;
    for (int i = 0; i < 4; i++) begin
      if (exp_v[slot][i]) exp_lane[i] = exp_d[slot][i];
      e_data[i*32 +: 32] = exp_lane[i];
    end
    n_vec++;
    if (rsp_valid !== exp_v[slot]) begin
      n_bad++;
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v[slot]);
    end
    n_vec++;
    if (rsp_data !== e_data) begin
      n_bad++;
      $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, e_data);
    end
    exp_v[slot] = '0;
    rq_valid = v; rq_addr = a; wr_valid = wv; wr_addr = wa; wr_data = wd;
    clr_start = cs; clr_value = cv;
    #1;
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    e_rdy = '0; e_r0 = '0; e_r1 = '0;
    nslot = (cyc + 2) % 4;
    if (order.size() > 0) begin
      e_rdy[order[0]] = 1'b1;
      e_r0 = a[order[0]*16 +: 16];
      exp_v[nslot][order[0]] = 1'b1;
      exp_d[nslot][order[0]] = model_mem[e_r0];
    end
    if (order.size() > 1) begin
      e_rdy[order[1]] = 1'b1;
      e_r1 = a[order[1]*16 +: 16];
      exp_v[nslot][order[1]] = 1'b1;
      exp_d[nslot][order[1]] = model_mem[e_r1];
    end
    if (order.size() > 0) begin
      last  = (order.size() > 1) ? order[1] : order[0];
      m_ptr = (last + 1) % 4;
    end
    // Clear runs on cycles start+1 .. start+65536, done pulse on start+65537.
    off    = (m_cs >= 0) ? (cyc - m_cs) : -1;
    in_clr = (off >= 1 && off <= 65536);
    e_busy = in_clr;
    e_wrdy = !in_clr;
    e_wr   = in_clr ? 1'b1 : wv;
    e_wa   = in_clr ? 16'(off - 1) : wa;
    e_wd   = in_clr ? m_cv : wd;
    e_done = (off == 65537);
    if (cs && CLR_EN && !(off >= 1 && off <= 65537)) begin
      m_cs = cyc;
      m_cv = cv;
    end
    n_vec++; if (rq_ready !== e_rdy) begin n_bad++; $display("FAIL rq_ready cyc=%0d got=%b exp=%b", cyc, rq_ready, e_rdy); end
    n_vec++; if (mem_read0 !== e_r0) begin n_bad++; $display("FAIL mem_read0 cyc=%0d got=%h exp=%h", cyc, mem_read0, e_r0); end
    n_vec++; if (mem_read1 !== e_r1) begin n_bad++; $display("FAIL mem_read1 cyc=%0d got=%h exp=%h", cyc, mem_read1, e_r1); end
    n_vec++; if (wr_ready !== e_wrdy) begin n_bad++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, e_wrdy); end
    n_vec++; if (mem_writing !== e_wr) begin n_bad++; $display("FAIL mem_writing cyc=%0d got=%b exp=%b", cyc, mem_writing, e_wr); end
    n_vec++; if (mem_waddr !== e_wa) begin n_bad++; $display("FAIL mem_waddr cyc=%0d got=%h exp=%h", cyc, mem_waddr, e_wa); end
    n_vec++; if (mem_wdata !== e_wd) begin n_bad++; $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wd); end
    n_vec++; if (clr_busy !== e_busy) begin n_bad++; $display("FAIL clr_busy cyc=%0d got=%b exp=%b", cyc, clr_busy, e_busy); end
    n_vec++; if (clr_done !== e_done) begin n_bad++; $display("FAIL clr_done cyc=%0d got=%b exp=%b", cyc, clr_done, e_done); end
    if (e_wr) model_mem[e_wa] = e_wd;
    cyc++;
  endtask

  task automatic idle_cycle();
    run_cycle(4'b0000, 64'h0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asserts reset immediately (mid-cycle) with busy inputs; all outputs must drop.
  task automatic test_reset();
    rst_n = 1'b0;
    rq_valid = 4'b1111; rq_addr = rand_addrs(); wr_valid = 1'b1;
    wr_addr = 16'($urandom()); wr_data = $urandom(); clr_start = 1'b1; clr_value = $urandom();
    #1;
    n_vec++; if (rq_ready !== 4'b0) begin n_bad++; $display("FAIL reset_rq_ready got=%b exp=0", rq_ready); end
    n_vec++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (rsp_data !== 128'b0) begin n_bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_vec++; if ({mem_read0, mem_read1} !== 32'b0) begin n_bad++; $display("FAIL reset_mem_read got=%h exp=0", {mem_read0, mem_read1}); end
    n_vec++; if (mem_writing !== 1'b0) begin n_bad++; $display("FAIL reset_mem_writing got=%b exp=0", mem_writing); end
    n_vec++; if ({mem_waddr, mem_wdata} !== 48'b0) begin n_bad++; $display("FAIL reset_mem_wport got=%h exp=0", {mem_waddr, mem_wdata}); end
    n_vec++; if ({wr_ready, clr_busy, clr_done} !== 3'b0) begin n_bad++; $display("FAIL reset_ctrl got=%b exp=000", {wr_ready, clr_busy, clr_done}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rq_valid = '0; rq_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_value = '0;
    model_reset();
  endtask

  task automatic test_rr_fixed();
    run_cycle(4'b1111, rand_addrs(), 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (rq_ready !== 4'b0011) begin n_bad++; $display("FAIL rr_first got=%b exp=0011", rq_ready); end
    run_cycle(4'b1111, rand_addrs(), 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (rq_ready !== 4'b1100) begin n_bad++; $display("FAIL rr_second got=%b exp=1100", rq_ready); end
    idle_cycle();
    n_vec++; if (rsp_valid !== 4'b0011) begin n_bad++; $display("FAIL rr_rsp1 got=%b exp=0011", rsp_valid); end
    idle_cycle();
    n_vec++; if (rsp_valid !== 4'b1100) begin n_bad++; $display("FAIL rr_rsp2 got=%b exp=1100", rsp_valid); end
  endtask

  task automatic test_directed_data();
    run_cycle(4'b0000, 64'h0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0);
    run_cycle(4'b0100, 64'h0000_0010_0000_0000, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    idle_cycle();
    idle_cycle();
    n_vec++; if (rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL lane2_valid got=%b exp=0100", rsp_valid); end
    n_vec++; if (rsp_data[95:64] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lane2_data got=%h exp=deadbeef", rsp_data[95:64]); end
  endtask

  task automatic test_same_addr();
    run_cycle(4'b0000, 64'h0, 1'b1, 16'h0005, 32'h0BADF00D, 1'b0, 32'h0);
    run_cycle(4'b0001, 64'h0005, 1'b1, 16'h0005, 32'h12345678, 1'b0, 32'h0);
    idle_cycle();
    run_cycle(4'b0001, 64'h0005, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (rsp_data[31:0] !== 32'h0BADF00D) begin n_bad++; $display("FAIL same_addr_old got=%h exp=0badf00d", rsp_data[31:0]); end
    idle_cycle();
    idle_cycle();
    n_vec++; if (rsp_data[31:0] !== 32'h12345678) begin n_bad++; $display("FAIL same_addr_new got=%h exp=12345678", rsp_data[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] e;
    logic [15:0] ad;
    for (int k = 0; k < 8; k++) begin
      ad = 16'h0100 + 16'(k);
      if (k < 6) begin
        q.push_back(model_mem[ad]);
        run_cycle(4'b0010, {32'h0, ad, 16'h0}, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
      end else begin
        idle_cycle();
      end
      if (k >= 2) begin
        e = q.pop_front();
        n_vec++;
        if (rsp_valid[1] !== 1'b1 || rsp_data[63:32] !== e) begin
          n_bad++;
          $display("FAIL b2b_lane1 k=%0d got=%b/%h exp=1/%h", k, rsp_valid[1], rsp_data[63:32], e);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [63:0] a;
    for (int i = 0; i < n; i++) begin
      a = rand_addrs();
      if ($urandom_range(1, 0) == 1) a = a & 64'h001F_001F_001F_001F;
      run_cycle(4'($urandom()), a, 1'($urandom()), 16'($urandom_range(31, 0)),
                $urandom(), 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset_inflight();
    run_cycle(4'b1111, rand_addrs(), 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    run_cycle(4'b1111, rand_addrs(), 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    test_reset();
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      n_vec++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL inflight_discard i=%0d got=%b exp=0", i, rsp_valid); end
    end
  endtask

`ifdef MEM_PORT_SCHED_CLEAR_EN
  task automatic test_clear();
    int nclr;
    logic [63:0] a;
    nclr = 0;
    run_cycle(4'b0000, 64'h0, 1'b1, 16'h1234, 32'h55AA55AA, 1'b1, 32'hA5A5A5A5);
    n_vec++; if (mem_writing !== 1'b1 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL clr_start_write got=%b%b exp=11", mem_writing, wr_ready); end
    for (int i = 0; i < 65536; i++) begin
      a = rand_addrs();
      run_cycle(($urandom_range(7, 0) == 0) ? 4'($urandom()) : 4'b0, a, 1'($urandom()),
                16'($urandom()), $urandom(), 1'($urandom()), $urandom());
      if (mem_writing === 1'b1 && wr_ready === 1'b0 && mem_waddr === 16'(i)) nclr++;
    end
    n_vec++; if (nclr != 65536) begin n_bad++; $display("FAIL clr_write_count got=%0d exp=65536", nclr); end
    idle_cycle();
    n_vec++; if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin n_bad++; $display("FAIL clr_done_pulse got=%b%b exp=10", clr_done, clr_busy); end
    idle_cycle();
    n_vec++; if (clr_done !== 1'b0 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL clr_after_done got=%b%b exp=01", clr_done, wr_ready); end
    run_cycle(4'b1000, 64'h8000_0000_0000_0000, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
    idle_cycle();
    idle_cycle();
    n_vec++; if (rsp_data[127:96] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL clr_readback got=%h exp=a5a5a5a5", rsp_data[127:96]); end
  endtask

  task automatic test_reset_mid_clear();
    run_cycle(4'b0000, 64'h0, 1'b0, 16'h0, 32'h0, 1'b1, $urandom());
    for (int i = 0; i < 256; i++) idle_cycle();
    @(negedge clk);
    rq_valid = '0; wr_valid = 1'b0; clr_start = 1'b0;
    #1;
    n_vec++; if (mem_waddr !== 16'h0100 || clr_busy !== 1'b1) begin n_bad++; $display("FAIL mid_clear_addr got=%h/%b exp=0100/1", mem_waddr, clr_busy); end
    test_reset();
    idle_cycle();
    n_vec++; if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL after_abort got=%b%b exp=01", clr_busy, wr_ready); end
  endtask
`else
  task automatic test_clear_disabled();
    run_cycle(4'b0000, 64'h0, 1'b0, 16'h0, 32'h0, 1'b1, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      n_vec++;
      if (mem_writing !== 1'b0 || clr_done !== 1'b0 || clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL clear_disabled i=%0d got=%b%b%b%b exp=0001", i, mem_writing, clr_done, clr_busy, wr_ready);
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    n_vec = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0;
    rq_valid = '0; rq_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_value = '0;
    for (int i = 0; i < 65536; i++) begin
      v = $urandom();
      tb_mem[i] = v;
      model_mem[i] = v;
    end
    model_reset();
    @(negedge clk);
    test_reset();
    test_rr_fixed();
    test_directed_data();
    test_same_addr();
    test_back_to_back();
    test_random(400);
    test_reset_inflight();
`ifdef MEM_PORT_SCHED_CLEAR_EN
    test_clear();
    test_random(50);
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    test_random(50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
